cv32e40p_instr_aligner: RTL and testbench

Realigns the 32-bit fetch words delivered by the prefetch buffer into whole RV32/RVC instructions. It tracks the instruction PC and holds the upper halfword of a word when an instruction straddles two fetch words. It sits directly upstream of the compressed-decoder stage. Its `instr_aligned_o` feeds `instr_i` of the decoder, with bits [15:0] always holding the first halfword of the instruction.

---
 rtl/cv32e40p_instr_aligner.sv | 146 ++++++++++++++
 tb/tb_cv32e40p_instr_aligner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_aligner.sv
// Instruction aligner: turns 32-bit fetch words into whole RV32/RVC instructions,
// tracking the PC and keeping the upper halfword when an instruction straddles two words.
module cv32e40p_instr_aligner (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_aligned_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        StAligned,
        StHalf,
        StBranchHalf
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_pc;
    logic [31:0] w_pc_d;
    logic [15:0] r_hold;
    logic [15:0] w_hold_d;

    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic        w_lo_is32;
    logic        w_hi_is32;
    logic        w_hold_is32;
    logic        w_instr_hs;
    logic        w_fetch_hs;

    assign w_lo        = fetch_rdata_i[15:0];
    assign w_hi        = fetch_rdata_i[31:16];
    assign w_lo_is32   = (w_lo[1:0] == 2'b11);
    assign w_hi_is32   = (w_hi[1:0] == 2'b11);
    assign w_hold_is32 = (r_hold[1:0] == 2'b11);
    assign w_instr_hs  = instr_valid_o & instr_ready_i;
    assign w_fetch_hs  = fetch_valid_i & fetch_ready_o;
    assign pc_o        = r_pc;

    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_hold_d        = r_hold;
        instr_valid_o   = 1'b0;
        fetch_ready_o   = 1'b0;
        instr_aligned_o = 32'h0;

        unique case (r_state)
            StAligned: begin
                if (w_lo_is32) begin
                    instr_aligned_o = fetch_rdata_i;
                    instr_valid_o   = fetch_valid_i;
                    fetch_ready_o   = instr_ready_i;
                    if (w_instr_hs) begin
                        w_pc_d = r_pc + 32'd4;
                    end
                end else begin
                    instr_aligned_o = {16'h0, w_lo};
                    instr_valid_o   = fetch_valid_i;
                    fetch_ready_o   = instr_ready_i;
                    if (w_instr_hs) begin
                        w_hold_d  = w_hi;
                        w_pc_d    = r_pc + 32'd2;
                        w_state_d = StHalf;
                    end
                end
            end
            StHalf: begin
                if (!w_hold_is32) begin
                    // RVC already held: issue without touching the fetch port
                    instr_aligned_o = {16'h0, r_hold};
                    instr_valid_o   = 1'b1;
                    fetch_ready_o   = 1'b0;
                    if (w_instr_hs) begin
                        w_pc_d    = r_pc + 32'd2;
                        w_state_d = StAligned;
                    end
                end else begin
                    instr_aligned_o = {w_lo, r_hold};
                    instr_valid_o   = fetch_valid_i;
                    fetch_ready_o   = instr_ready_i;
                    if (w_instr_hs) begin
                        w_hold_d = w_hi;
                        w_pc_d   = r_pc + 32'd4;
                    end
                end
            end
            StBranchHalf: begin
                instr_aligned_o = {16'h0, w_hi};
                if (!w_hi_is32) begin
                    instr_valid_o = fetch_valid_i;
                    fetch_ready_o = instr_ready_i;
                    if (w_instr_hs) begin
                        w_pc_d    = r_pc + 32'd2;
                        w_state_d = StAligned;
                    end
                end else begin
                    // First half of a 32-bit target: swallow the word silently
                    instr_valid_o = 1'b0;
                    fetch_ready_o = 1'b1;
                    if (w_fetch_hs) begin
                        w_hold_d  = w_hi;
                        w_state_d = StHalf;
                    end
                end
            end
            default: begin
                w_state_d = StAligned;
            end
        endcase

        if (branch_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
            w_pc_d        = branch_addr_i & ~32'h1;
            w_hold_d      = r_hold;
            w_state_d     = branch_addr_i[1] ? StBranchHalf : StAligned;
        end

        if (rst) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StAligned;
            r_pc    <= boot_addr_i & ~32'h3;
            r_hold  <= 16'h0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_hold  <= w_hold_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// Directed self-checking bench for cv32e40p_instr_aligner.
module tb_cv32e40p_instr_aligner;

    logic        clk;
    logic        rst;
    logic [31:0] boot_addr_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_aligned_o;
    logic [31:0] pc_o;

    int n_checks;
    int n_pass;

    cv32e40p_instr_aligner u_dut (
        .clk            (clk),
        .rst            (rst),
        .boot_addr_i    (boot_addr_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_ready_o  (fetch_ready_o),
        .fetch_rdata_i  (fetch_rdata_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_aligned_o(instr_aligned_o),
        .pc_o           (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    task automatic do_branch(input logic [31:0] addr);
        branch_i      = 1'b1;
        branch_addr_i = addr;
        step();
        branch_i      = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        boot_addr_i   = 32'h0000_0083;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h00A0_0093;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        instr_ready_i = 1'b1;

        // Reset forces handshake outputs low
        step();
        settle();
        chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("rst_fready", {31'h0, fetch_ready_o}, 32'h0);
        rst = 1'b0;
        settle();
        chk("boot_pc", pc_o, 32'h0000_0080);
        chk("w32_instr", instr_aligned_o, 32'h00A0_0093);
        chk("w32_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("w32_fready", {31'h0, fetch_ready_o}, 32'h1);
        step();
        fetch_valid_i = 1'b0;
        settle();
        chk("w32_pc_next", pc_o, 32'h0000_0084);

        // Branch colliding with a would-be handshake
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h00B7_4501;
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0080;
        settle();
        chk("br_coll_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("br_coll_fready", {31'h0, fetch_ready_o}, 32'h0);
        step();
        branch_i = 1'b0;
        settle();
        chk("br_coll_pc", pc_o, 32'h0000_0080);

        // Straddling instruction
        chk("str_rvc", instr_aligned_o, 32'h0000_4501);
        step();
        fetch_rdata_i = 32'h1234_5678;
        settle();
        chk("str_pc1", pc_o, 32'h0000_0082);
        chk("str_32", instr_aligned_o, 32'h5678_00B7);
        chk("str_valid", {31'h0, instr_valid_o}, 32'h1);
        step();
        fetch_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        settle();
        chk("str_pc2", pc_o, 32'h0000_0086);

        // Backpressure in HALF with held RVC 0x1234
        for (int i = 0; i < 3; i++) begin
            chk("bp_instr", instr_aligned_o, 32'h0000_1234);
            chk("bp_valid", {31'h0, instr_valid_o}, 32'h1);
            chk("bp_fready", {31'h0, fetch_ready_o}, 32'h0);
            chk("bp_pc", pc_o, 32'h0000_0086);
            step();
            settle();
        end
        instr_ready_i = 1'b1;
        step();
        settle();
        chk("bp_rel_pc", pc_o, 32'h0000_0088);
        chk("bp_rel_valid", {31'h0, instr_valid_o}, 32'h0);

        // Two RVC in one word
        do_branch(32'h0000_0100);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h4585_4501;
        settle();
        chk("rvc2_a", instr_aligned_o, 32'h0000_4501);
        chk("rvc2_a_pc", pc_o, 32'h0000_0100);
        chk("rvc2_a_fready", {31'h0, fetch_ready_o}, 32'h1);
        step();
        fetch_valid_i = 1'b0;
        settle();
        chk("rvc2_b", instr_aligned_o, 32'h0000_4585);
        chk("rvc2_b_pc", pc_o, 32'h0000_0102);
        chk("rvc2_b_fready", {31'h0, fetch_ready_o}, 32'h0);
        chk("rvc2_b_valid", {31'h0, instr_valid_o}, 32'h1);
        step();
        settle();
        chk("rvc2_end_pc", pc_o, 32'h0000_0104);
        chk("rvc2_end_valid", {31'h0, instr_valid_o}, 32'h0);

        // Misaligned branch target, RVC
        do_branch(32'h0000_0203);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h4505_0013;
        settle();
        chk("bh16_instr", instr_aligned_o, 32'h0000_4505);
        chk("bh16_pc", pc_o, 32'h0000_0202);
        step();
        fetch_valid_i = 1'b0;
        settle();
        chk("bh16_pc_next", pc_o, 32'h0000_0204);
        chk("bh16_valid_next", {31'h0, instr_valid_o}, 32'h0);

        // Misaligned branch target, 32-bit
        do_branch(32'h0000_0302);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0093_FFFF;
        settle();
        chk("bh32_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("bh32_fready", {31'h0, fetch_ready_o}, 32'h1);
        step();
        fetch_rdata_i = 32'hAAAA_00A0;
        settle();
        chk("bh32_instr", instr_aligned_o, 32'h00A0_0093);
        chk("bh32_pc", pc_o, 32'h0000_0302);
        chk("bh32_valid2", {31'h0, instr_valid_o}, 32'h1);
        step();
        fetch_valid_i = 1'b0;
        settle();
        chk("bh32_pc_next", pc_o, 32'h0000_0306);
        chk("half_rvc_hold", instr_aligned_o, 32'h0000_AAAA);

        // Reset while in HALF drops the held halfword
        boot_addr_i = 32'h0000_1002;
        rst         = 1'b1;
        settle();
        chk("rst_half_valid", {31'h0, instr_valid_o}, 32'h0);
        step();
        rst = 1'b0;
        settle();
        chk("rst_half_pc", pc_o, 32'h0000_1000);
        chk("rst_half_valid2", {31'h0, instr_valid_o}, 32'h0);

        // PC wrap
        do_branch(32'hFFFF_FFFE);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h4501_0000;
        settle();
        chk("wrap_instr", instr_aligned_o, 32'h0000_4501);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFE);
        step();
        fetch_valid_i = 1'b0;
        settle();
        chk("wrap_pc_next", pc_o, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
